// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DP_DIGIT   = 2;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low one-cold anode select for a digit slot.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 show a dash (segment g only).
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: the default arm keeps every input code assigned, so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_4dig.sv
// Four-digit multiplexed seven-segment scanner with frame-coherent shadow digits.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_4dig
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       carry,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int         PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam digit_idx_t LAST_IDX  = digit_idx_t'(NUM_DIGITS - 1);
  localparam digit_idx_t DP_IDX    = digit_idx_t'(DP_DIGIT);

  logic [PW-1:0] presc;
  logic          tick;
  digit_idx_t    idx;
  bcd_t          shadow [NUM_DIGITS];
  logic          dp_state;
  bcd_t          cur_digit;
  seg_t          dec_seg;
  seg_t          next_seg;

  assign tick = enable && (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      // NOTE: the shadow bank is only four nibbles and must read as zero after reset, so it is reset like ordinary flops.
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else if (enable) begin
      // NOTE: non-blocking updates let every flop here sample the pre-edge idx and presc.
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= idx + 1'b1;
        // The whole frame is latched together on the 3->0 wrap so a frame never tears.
        if (idx == LAST_IDX) begin
          shadow[3] <= digit3;
          shadow[2] <= digit2;
          shadow[1] <= digit1;
          shadow[0] <= digit0;
        end
      end
    end
  end

  // Carry toggles are independent of scanning, so a carry on a wrap edge is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      dp_state <= 1'b0;
    else if (carry) dp_state <= ~dp_state;
  end

  assign cur_digit = shadow[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // A digit blanks only when it and everything above it are zero; digit0 always shows.
  always_comb begin
    lead_zero    = '0;
    lead_zero[3] = (shadow[3] == '0);
    lead_zero[2] = lead_zero[3] && (shadow[2] == '0);
    lead_zero[1] = lead_zero[2] && (shadow[1] == '0);
  end

  assign next_seg = lead_zero[idx] ? SEG_BLANK : dec_seg;
`else
  assign next_seg = dec_seg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= anode_sel(idx);
      seg <= next_seg;
      dp  <= !((idx == DP_IDX) && dp_state);
    end
  end

endmodule

// File: tb/tb_seg7_scan_4dig.sv
// Self-checking bench for seg7_scan_4dig: table-driven frames plus hand-written
// tearing, hold, carry and mid-frame reset sequences, checked through a scoreboard queue.
module tb_seg7_scan_4dig;

  localparam int SCAN_DIV = 4;
  localparam int BUDGET   = 4 * SCAN_DIV + 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = SB;
`else
  localparam logic [6:0] ZB = S0;
`endif

  typedef struct packed {
    logic [3:0][3:0] d;    // {digit3, digit2, digit1, digit0}
    logic [3:0][6:0] seg;  // expected pattern for slot 3..0
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, enable, carry;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q [$];
  vec_t tbl  [7];
  vec_t zero_v, tear1, tear2, v2468;

  seg7_scan_4dig #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .digit3 (digit3),
    .digit2 (digit2),
    .digit1 (digit1),
    .digit0 (digit0),
    .carry  (carry),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int s);
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic push_slot(input int s, input logic [6:0] sg, input logic dp_on);
    exp_t e;
    e.an  = an_of(s);
    e.seg = sg;
    e.dp  = !(s == 2 && dp_on);
    sb_q.push_back(e);
  endtask

  task automatic push_frame(input vec_t v, input int first, input logic dp_on);
    for (int s = first; s < 4; s++) push_slot(s, v.seg[s], dp_on);
  endtask

  task automatic drive(input vec_t v);
    {digit3, digit2, digit1, digit0} = v.d;
  endtask

  // Wait (bounded) for the next anode change, then pop and compare one expectation.
  task automatic next_slot(input int exp_gap, input string tag);
    exp_t       e;
    logic [3:0] prev;
    int         n;
    prev = an;
    n    = 0;
    while (an === prev && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_sb: no expectation queued, an=%b", tag, an);
    end else begin
      e = sb_q.pop_front();
      if (an === prev) begin
        n_cmp++;
        n_mis++;
        $display("FAIL %s_timeout: an held %b for %0d cycles, required change to %b", tag, prev, n, e.an);
      end else begin
        check({tag, "_an"}, 32'(an), 32'(e.an));
        check({tag, "_seg"}, 32'(seg), 32'(e.seg));
        check({tag, "_dp"}, 32'(dp), 32'(e.dp));
        if (exp_gap != 0) check({tag, "_gap"}, 32'(n), 32'(exp_gap));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    carry  = 1'b0;
    {digit3, digit2, digit1, digit0} = '0;

    tbl[0] = '{d: {4'd5, 4'd9, 4'd3, 4'd7}, seg: {S5, S9, S3, S7}};
    tbl[1] = '{d: {4'd8, 4'd6, 4'd4, 4'd2}, seg: {S8, S6, S4, S2}};
    tbl[2] = '{d: {4'hF, 4'hA, 4'hB, 4'hD}, seg: {SD, SD, SD, SD}};
    tbl[3] = '{d: {4'd0, 4'd0, 4'd4, 4'd0}, seg: {ZB, ZB, S4, S0}};
    tbl[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd0}, seg: {ZB, ZB, ZB, S0}};
    tbl[5] = '{d: {4'd0, 4'd3, 4'd0, 4'd1}, seg: {ZB, S3, S0, S1}};
    tbl[6] = '{d: {4'd1, 4'd0, 4'hC, 4'd7}, seg: {S1, S0, SD, S7}};
    zero_v = '{d: {4'd0, 4'd0, 4'd0, 4'd0}, seg: {ZB, ZB, ZB, S0}};
    tear1  = '{d: {4'd1, 4'd0, 4'hC, 4'd2}, seg: {S1, S0, SD, S2}};
    tear2  = '{d: {4'd1, 4'd0, 4'hC, 4'd9}, seg: {S1, S0, SD, S9}};
    v2468  = '{d: {4'd2, 4'd4, 4'd6, 4'd8}, seg: {S2, S4, S6, S8}};

    // Reset state, before and after a clock edge, then first registered output.
    #5;
    check("rst_an", 32'(an), 32'(4'b1111));
    check("rst_seg", 32'(seg), 32'(SB));
    check("rst_dp", 32'(dp), 32'(1'b1));
    @(negedge clk);
    check("rst_edge_an", 32'(an), 32'(4'b1111));
    reset = 1'b0;
    @(negedge clk);
    check("rel_an", 32'(an), 32'(4'b1110));
    check("rel_seg", 32'(seg), 32'(S0));
    check("rel_dp", 32'(dp), 32'(1'b1));

    // First frame still shows the all-zero shadow; tbl[0] is captured at its end.
    drive(tbl[0]);
    enable = 1'b1;
    push_frame(zero_v, 1, 1'b0);
    next_slot(0, "f0_s1");
    next_slot(SCAN_DIV, "f0_s2");
    next_slot(SCAN_DIV, "f0_s3");

    // Each frame shows the previous vector while the next one is driven mid-frame.
    for (int i = 1; i < 7; i++) begin
      push_frame(tbl[i-1], 0, 1'b0);
      next_slot(SCAN_DIV, $sformatf("v%0d_s0", i - 1));
      drive(tbl[i]);
      for (int s = 1; s < 4; s++) next_slot(SCAN_DIV, $sformatf("v%0d_s%0d", i - 1, s));
    end

    // Tearing: digit0 7->2 just before the wrap edge, then 2->9 just after it.
    push_frame(tbl[6], 0, 1'b0);
    for (int s = 0; s < 4; s++) next_slot(SCAN_DIV, $sformatf("v6_s%0d", s));
    @(negedge clk);
    @(negedge clk);
    digit0 = 4'd2;
    @(negedge clk);
    check("tear_wrap_an", 32'(an), 32'(4'b0111));
    check("tear_wrap_seg", 32'(seg), 32'(S1));
    digit0 = 4'd9;
    push_frame(tear1, 0, 1'b0);
    next_slot(1, "tear_s0");

    // Hold: dash in slot 1 stays put while enable is low.
    next_slot(SCAN_DIV, "hold_s1");
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_an_c%0d", c), 32'(an), 32'(4'b1101));
      check($sformatf("hold_seg_c%0d", c), 32'(seg), 32'(SD));
    end
    enable = 1'b1;
    next_slot(SCAN_DIV, "hold_s2");
    next_slot(SCAN_DIV, "hold_s3");

    // Carry 1 in slot 0: decimal point lights in slot 2.
    push_slot(0, tear2.seg[0], 1'b0);
    next_slot(SCAN_DIV, "cy1_s0");
    carry = 1'b1;
    @(negedge clk);
    carry = 1'b0;
    push_frame(tear2, 1, 1'b1);
    next_slot(SCAN_DIV - 1, "cy1_s1");
    next_slot(SCAN_DIV, "cy1_s2");
    next_slot(SCAN_DIV, "cy1_s3");

    // Carry 2 on the wrap edge together with new digits: both must take effect.
    @(negedge clk);
    @(negedge clk);
    carry = 1'b1;
    drive(v2468);
    @(negedge clk);
    carry = 1'b0;
    check("cy2_wrap_an", 32'(an), 32'(4'b0111));
    push_frame(v2468, 0, 1'b0);
    next_slot(1, "cy2_s0");
    for (int s = 1; s < 4; s++) next_slot(SCAN_DIV, $sformatf("cy2_s%0d", s));

    // Mid-frame asynchronous reset with dp_state set and non-zero shadows.
    push_slot(0, v2468.seg[0], 1'b0);
    push_slot(1, v2468.seg[1], 1'b0);
    next_slot(SCAN_DIV, "mr_s0");
    next_slot(SCAN_DIV, "mr_s1");
    carry = 1'b1;
    @(negedge clk);
    carry = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("mr_async_an", 32'(an), 32'(4'b1111));
    check("mr_async_seg", 32'(seg), 32'(SB));
    check("mr_async_dp", 32'(dp), 32'(1'b1));
    @(negedge clk);
    check("mr_hold_an", 32'(an), 32'(4'b1111));
    reset = 1'b0;
    @(negedge clk);
    check("mr_rel_an", 32'(an), 32'(4'b1110));
    check("mr_rel_seg", 32'(seg), 32'(S0));
    check("mr_rel_dp", 32'(dp), 32'(1'b1));
    push_frame(zero_v, 1, 1'b0);
    for (int s = 1; s < 4; s++) next_slot(SCAN_DIV, $sformatf("mr_post_s%0d", s));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
